// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage PC redirect and wrong-path flush sequencer (optional BRANCH_STATS_EN outcome counters)
module branch_resolver #(
  parameter int PC_WIDTH = 32,
  parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                BranchE,
  input  logic                ValidE,
  input  logic                CondEx,
  input  logic                StallE,
  input  logic                StallF,
  input  logic [PC_WIDTH-1:0] BranchTargetE,
  output logic                PCSrcE,
  output logic [PC_WIDTH-1:0] BranchTargetOut,
  output logic                FlushD,
  output logic                FlushE,
  output logic                Busy
`ifdef BRANCH_STATS_EN
  , output logic [CNT_WIDTH-1:0] TakenCount,
  output logic [CNT_WIDTH-1:0] NotTakenCount
`endif
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic qual, take;
  assign qual = BranchE & ValidE & ~StallE & (state_q == IDLE);
  assign take = qual & CondEx;
  // next state: redirect holds while fetch stalls, then count down the bubble cycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = take ? REDIRECT : IDLE;
      REDIRECT: begin
        state_d = StallF ? REDIRECT : (FLUSH_CYCLES == 1 ? IDLE : FLUSH);
        cnt_d = StallF ? cnt_q : 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        state_d = cnt_q <= 4'd1 ? IDLE : FLUSH;
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, captured target and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      BranchTargetOut <= '0;
      PCSrcE <= 1'b0;
      FlushD <= 1'b0;
      FlushE <= 1'b0;
      Busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (take) BranchTargetOut <= BranchTargetE;
      PCSrcE <= state_d == REDIRECT;
      FlushD <= state_d != IDLE;
      FlushE <= state_d != IDLE;
      Busy <= state_d != IDLE;
    end
  end
`ifdef BRANCH_STATS_EN
  // saturating counts of branch outcomes decided in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      TakenCount <= '0;
      NotTakenCount <= '0;
    end else begin
      if (take && !(&TakenCount)) TakenCount <= TakenCount + CNT_WIDTH'(1);
      if (qual && !CondEx && !(&NotTakenCount)) NotTakenCount <= NotTakenCount + CNT_WIDTH'(1);
    end
  end
`else
  // outcome counters are not built
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of redirect, flush sequencing, stalls, wrong-path and reset
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst, BranchE, ValidE, CondEx, StallE, StallF;
  logic [31:0] BranchTargetE, BranchTargetOut;
  logic PCSrcE, FlushD, FlushE, Busy;
  logic [3:0] o;
  int total = 0;
  int bad = 0;
  assign o = {PCSrcE, FlushD, FlushE, Busy};
  always #5 clk = ~clk;
  branch_resolver #(.PC_WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .BranchE(BranchE), .ValidE(ValidE), .CondEx(CondEx),
    .StallE(StallE), .StallF(StallF), .BranchTargetE(BranchTargetE),
    .PCSrcE(PCSrcE), .BranchTargetOut(BranchTargetOut), .FlushD(FlushD),
    .FlushE(FlushE), .Busy(Busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    BranchE = 0; ValidE = 0; CondEx = 0; StallE = 0; StallF = 0; BranchTargetE = '0;
  endtask
  task automatic br(input logic c, input logic [31:0] t);
    BranchE = 1; ValidE = 1; CondEx = c; StallE = 0; BranchTargetE = t;
  endtask
  task automatic drain();
    clr();
    repeat (4) step();
  endtask
  task automatic test_reset();
    rst = 1;
    clr();
    step();
    step();
    rst = 0;
    total++;
    if (o !== 4'b0000 || BranchTargetOut !== 32'h0) begin
      bad++;
      $display("FAIL reset: got o=%b tgt=%h want o=0000 tgt=0", o, BranchTargetOut);
    end
  endtask
  task automatic test_taken();
    logic [3:0] e [3] = '{4'b1111, 4'b0111, 4'b0000};
    br(1, 32'h40);
    step();
    clr();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o !== e[i] || BranchTargetOut !== 32'h40) begin
        bad++;
        $display("FAIL taken[%0d]: got o=%b tgt=%h want o=%b tgt=00000040", i, o, BranchTargetOut, e[i]);
      end
      step();
    end
  endtask
  task automatic test_not_taken();
    br(0, 32'h44);
    step();
    clr();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o !== 4'b0000) begin
        bad++;
        $display("FAIL not_taken[%0d]: got o=%b want o=0000", i, o);
      end
      step();
    end
  endtask
  task automatic test_fetch_stall();
    logic [3:0] e [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
    br(1, 32'h100);
    step();
    clr();
    for (int i = 0; i < 6; i++) begin
      StallF = i < 3;
      total++;
      if (o !== e[i] || BranchTargetOut !== 32'h100) begin
        bad++;
        $display("FAIL fetch_stall[%0d]: got o=%b tgt=%h want o=%b tgt=00000100", i, o, BranchTargetOut, e[i]);
      end
      step();
    end
    drain();
  endtask
  task automatic test_wrong_path();
    logic [3:0] e [4] = '{4'b1111, 4'b0111, 4'b0000, 4'b0000};
    br(1, 32'h40);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) br(1, 32'h80);
      else clr();
      total++;
      if (o !== e[i] || BranchTargetOut !== 32'h40) begin
        bad++;
        $display("FAIL wrong_path[%0d]: got o=%b tgt=%h want o=%b tgt=00000040", i, o, BranchTargetOut, e[i]);
      end
      step();
    end
  endtask
  task automatic test_reset_mid();
    br(1, 32'h40);
    step();
    clr();
    step();
    total++;
    if (o !== 4'b0111) begin
      bad++;
      $display("FAIL reset_mid_flush: got o=%b want o=0111", o);
    end
    rst = 1;
    step();
    rst = 0;
    total++;
    if (o !== 4'b0000 || BranchTargetOut !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_clear: got o=%b tgt=%h want o=0000 tgt=0", o, BranchTargetOut);
    end
    br(1, 32'hC0);
    step();
    clr();
    total++;
    if (o !== 4'b1111 || BranchTargetOut !== 32'hC0) begin
      bad++;
      $display("FAIL reset_mid_new: got o=%b tgt=%h want o=1111 tgt=000000c0", o, BranchTargetOut);
    end
    drain();
  endtask
  task automatic test_stall_e();
    br(1, 32'h200);
    StallE = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (o !== 4'b0000) begin
        bad++;
        $display("FAIL stall_e_hold[%0d]: got o=%b want o=0000", i, o);
      end
    end
    StallE = 0;
    step();
    clr();
    total++;
    if (o !== 4'b1111 || BranchTargetOut !== 32'h200) begin
      bad++;
      $display("FAIL stall_e_release: got o=%b tgt=%h want o=1111 tgt=00000200", o, BranchTargetOut);
    end
    drain();
  endtask
  task automatic test_invalid();
    br(1, 32'h300);
    ValidE = 0;
    step();
    clr();
    total++;
    if (o !== 4'b0000 || BranchTargetOut === 32'h300) begin
      bad++;
      $display("FAIL invalid: got o=%b tgt=%h want o=0000 tgt!=00000300", o, BranchTargetOut);
    end
  endtask
  task automatic test_back_to_back();
    br(1, 32'h10);
    step();
    clr();
    step();
    br(1, 32'h20);
    step();
    total++;
    if (o !== 4'b0000 || BranchTargetOut !== 32'h10) begin
      bad++;
      $display("FAIL b2b_idle: got o=%b tgt=%h want o=0000 tgt=00000010", o, BranchTargetOut);
    end
    step();
    clr();
    total++;
    if (o !== 4'b1111 || BranchTargetOut !== 32'h20) begin
      bad++;
      $display("FAIL b2b_second: got o=%b tgt=%h want o=1111 tgt=00000020", o, BranchTargetOut);
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_fetch_stall();
    test_wrong_path();
    test_reset_mid();
    test_stall_e();
    test_invalid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
